seg7_port_display: RTL

- Output-side peripheral directly downstream of the CPU's memory-stage I/O ports; consumes the three 32-bit output port registers (out_port0..2).
- Renders out_port0..2 as decimal on an 8-digit multiplexed 7-segment display.
- A sequential double-dabble converter refreshes one port at a time.
- A scan counter time-multiplexes the digits.

---
 rtl/seg7_port_display_pkg.sv | 57 +++++
 rtl/seg7_port_display_bin2bcd_seq.sv | 76 +++++++
 rtl/seg7_port_display.sv | 114 +++++++++++
 3 files changed

// File: rtl/seg7_port_display_pkg.sv
// Shared constants for the port display: segment codes, converter states,
// clamp limits and small helpers used by the top and the converter.
package seg7_port_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } conv_state_e;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  localparam logic [BIN_W-1:0] LIM_2DIG = 14'd99;
  localparam logic [BIN_W-1:0] LIM_4DIG = 14'd9999;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Unsigned saturation of a 32-bit port value to a displayable limit.
  function automatic logic [BIN_W-1:0] clamp(input logic [31:0] v,
                                             input logic [BIN_W-1:0] lim);
    logic [BIN_W-1:0] r;
    if (v > {{(32-BIN_W){1'b0}}, lim}) r = lim;
    else                              r = v[BIN_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/seg7_port_display_bin2bcd_seq.sv
// Sequential double-dabble converter: LOAD (1) + SHIFT (14) + STORE (1).
// start_i is level-sampled in LOAD; done_o is high for the single STORE cycle.
module bin2bcd_seq
  import seg7_port_display_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              done_o,
  output logic [BCD_W-1:0]  bcd_o,
  output logic [1:0]        state_o
);

  conv_state_e        state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(BIN_W - 1)) state_d = ST_STORE;
      end
      ST_STORE: begin
        done_o  = 1'b1;
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_LOAD;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bcd_o   = bcd_q;
  assign state_o = state_q;

endmodule

// File: rtl/seg7_port_display.sv
// Decimal 8-digit multiplexed display of three CPU output ports.
// Ports are converted one at a time; digits are scanned by a free-running divider.
module seg7_port_display
  import seg7_port_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp,
  output logic        frame_done
);

  logic [1:0]        p_q, p_d;
  logic [BIN_W-1:0]  conv_in;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;
  logic [1:0]        conv_state;
  logic              store_en;
  logic [3:0]        dig_q [8];
  logic              frame_done_q;

  logic [CNT_W-1:0]  div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic              div_wrap;
  logic [7:0]        an_q;
  logic [6:0]        seg_q;

  // Port mux and clamp; the converter only samples this in LOAD.
  always_comb begin
    conv_in = '0;
    case (p_q)
      2'd0:    conv_in = clamp(out_port0, LIM_2DIG);
      2'd1:    conv_in = clamp(out_port1, LIM_2DIG);
      default: conv_in = clamp(out_port2, LIM_4DIG);
    endcase
  end

  bin2bcd_seq u_conv (
    .clock   (clock),
    .resetn  (resetn),
    .start_i (1'b1),
    .bin_i   (conv_in),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .state_o (conv_state)
  );

  assign store_en = conv_done && (conv_state == ST_STORE);

  always_comb begin
    p_d = p_q;
    if (store_en) p_d = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      p_q          <= 2'd0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 8; i++) dig_q[i] <= 4'd0;
    end else begin
      p_q          <= p_d;
      frame_done_q <= store_en && (p_q == 2'd2);
      if (store_en) begin
        case (p_q)
          2'd0: begin
            dig_q[7] <= conv_bcd[7:4];
            dig_q[6] <= conv_bcd[3:0];
          end
          2'd1: begin
            dig_q[5] <= conv_bcd[7:4];
            dig_q[4] <= conv_bcd[3:0];
          end
          default: begin
            dig_q[3] <= conv_bcd[15:12];
            dig_q[2] <= conv_bcd[11:8];
            dig_q[1] <= conv_bcd[7:4];
            dig_q[0] <= conv_bcd[3:0];
          end
        endcase
      end
    end
  end

  assign div_wrap = (div_q == CNT_W'(SCAN_DIV - 1));
  assign div_d    = div_wrap ? '0 : div_q + 1'b1;
  assign idx_d    = div_wrap ? idx_q + 3'd1 : idx_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      div_q <= '0;
      idx_q <= 3'd0;
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= ~(8'b1 << idx_q);
      seg_q <= seg_decode(dig_q[idx_q]);
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule
